// File: rtl/dmem_copy_engine_if.sv
// Bus bundle for dmem_copy_engine: request/status lines plus the data-memory port.
// The checksum line exists only when DMA_CHECKSUM_EN is defined.
interface dmem_copy_engine_if #(
    parameter int dataWidth = 32,
    parameter int lenWidth  = 6
);
    logic                 start;
    logic [dataWidth-1:0] srcAdrs;
    logic [dataWidth-1:0] dstAdrs;
    logic [lenWidth-1:0]  len;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic                 memWE;
    logic [dataWidth-1:0] memAdrs;
    logic [dataWidth-1:0] memWD;
    logic [dataWidth-1:0] memRData;
    logic [1:0]           dbgState;
`ifdef DMA_CHECKSUM_EN
    logic [dataWidth-1:0] checksum;
`endif

    modport master (
        input  start, srcAdrs, dstAdrs, len, memRData,
        output busy, done, err, memWE, memAdrs, memWD, dbgState
`ifdef DMA_CHECKSUM_EN
        , output checksum
`endif
    );

    modport slave (
        output start, srcAdrs, dstAdrs, len, memRData,
        input  busy, done, err, memWE, memAdrs, memWD, dbgState
`ifdef DMA_CHECKSUM_EN
        , input checksum
`endif
    );
endinterface

// File: rtl/dmem_copy_engine.sv
// Block-copy bus master: reads len words from srcAdrs and writes them ascending to dstAdrs.
// Optional running checksum of copied words when DMA_CHECKSUM_EN is defined.
module dmem_copy_engine #(
    parameter int dataWidth = 32,
    parameter int memDepth  = 48,
    parameter int lenWidth  = 6
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    dmem_copy_engine_if.master    bus
);
    // Handshake: start is a one-cycle request honoured only in IDLE (never queued);
    // done is a one-cycle completion pulse, and busy marks ownership of the memory port.
    localparam int AW = dataWidth + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state, w_next;
    logic [dataWidth-1:0] r_src, r_dst, r_buf, r_adrs_hold;
    logic [lenWidth-1:0]  r_len, r_cnt;
    logic                 r_err;
    logic [AW-1:0]        w_src_end, w_dst_end;
    logic                 w_range_bad, w_last, w_accept;
    logic [dataWidth-1:0] w_adrs;

    // One extra bit so address + len can never wrap past the range check.
    assign w_src_end   = {1'b0, bus.srcAdrs} + AW'(bus.len);
    assign w_dst_end   = {1'b0, bus.dstAdrs} + AW'(bus.len);
    assign w_range_bad = (w_src_end > AW'(memDepth)) || (w_dst_end > AW'(memDepth));
    assign w_last      = ({1'b0, r_cnt} + (lenWidth+1)'(1)) == {1'b0, r_len};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_adrs    = r_adrs_hold;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        bus.memWE = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    if (bus.len == '0 || w_range_bad) w_next = S_DONE;
                    else                              w_next = S_READ;
                end
            end
            S_READ: begin
                bus.busy = 1'b1;
                w_adrs   = r_src + dataWidth'(r_cnt);
                w_next   = S_WRITE;
            end
            S_WRITE: begin
                bus.busy  = 1'b1;
                bus.memWE = 1'b1;
                w_adrs    = r_dst + dataWidth'(r_cnt);
                w_next    = w_last ? S_DONE : S_READ;
            end
            S_DONE: begin
                bus.done = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

`ifdef DMA_CHECKSUM_EN
    logic [dataWidth-1:0] r_sum;
    assign bus.checksum = r_sum;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_src       <= '0;
            r_dst       <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_buf       <= '0;
            r_adrs_hold <= '0;
            r_err       <= 1'b0;
`ifdef DMA_CHECKSUM_EN
            r_sum       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_src <= bus.srcAdrs;
                        r_dst <= bus.dstAdrs;
                        r_len <= bus.len;
                        r_cnt <= '0;
                        // A zero-length request is a clean no-op even if the base is out of range.
                        r_err <= (bus.len != '0) && w_range_bad;
`ifdef DMA_CHECKSUM_EN
                        r_sum <= '0;
`endif
                    end
                end
                S_READ: begin
                    r_buf       <= bus.memRData;
                    r_adrs_hold <= w_adrs;
                end
                S_WRITE: begin
                    r_cnt       <= r_cnt + 1'b1;
                    r_adrs_hold <= w_adrs;
`ifdef DMA_CHECKSUM_EN
                    r_sum       <= r_sum + r_buf;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.memAdrs  = w_adrs;
    assign bus.memWD    = r_buf;
    assign bus.err      = r_err;
    assign bus.dbgState = r_state;
endmodule

// File: tb/tb_dmem_copy_engine.sv
// Scoreboard bench for dmem_copy_engine with a behavioural 48-word memory.
module tb_dmem_copy_engine;
    localparam int DW    = 32;
    localparam int LW    = 6;
    localparam int DEPTH = 48;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    dmem_copy_engine_if #(.dataWidth(DW), .lenWidth(LW)) bus ();

    dmem_copy_engine #(.dataWidth(DW), .memDepth(DEPTH), .lenWidth(LW)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    logic [DW-1:0] mem [DEPTH];
    logic          ld_en  = 1'b0;
    logic [5:0]    ld_adr = '0;
    logic [DW-1:0] ld_dat = '0;

    always @(posedge CLK) begin
        if (ld_en) mem[ld_adr] <= ld_dat;
        else if (bus.memWE && bus.memAdrs < DEPTH) mem[bus.memAdrs[5:0]] <= bus.memWD;
    end
    assign bus.memRData = (bus.memAdrs < DEPTH) ? mem[bus.memAdrs[5:0]] : '0;

    int total = 0;
    int bad   = 0;

    logic [63:0]   exp_wr_q[$];
    logic          exp_err_q[$];
    logic [7:0]    exp_busy_q[$];
    logic [DW-1:0] exp_sum_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT writes memory or pulses done.
    int busy_cnt = 0;
    always @(negedge CLK) begin
        if (!RST_N) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.memWE) begin
                if (exp_wr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: adrs=%0d data=%0h", bus.memAdrs, bus.memWD);
                end else begin
                    check("write", {bus.memAdrs, bus.memWD}, exp_wr_q.pop_front());
                end
            end
            if (bus.done) begin
                if (exp_err_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: err=%0d", bus.err);
                end else begin
                    logic [DW-1:0] es;
                    check("done_err", 64'(bus.err), 64'(exp_err_q.pop_front()));
                    check("busy_cycles", 64'(busy_cnt), 64'(exp_busy_q.pop_front()));
                    es = exp_sum_q.pop_front();
`ifdef DMA_CHECKSUM_EN
                    check("checksum", 64'(bus.checksum), 64'(es));
`endif
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic poke(input int adr, input logic [DW-1:0] dat);
        ld_adr = adr[5:0];
        ld_dat = dat;
        ld_en  = 1'b1;
        @(posedge CLK);
        #1 ld_en = 1'b0;
    endtask

    task automatic req(input logic [DW-1:0] s, input logic [DW-1:0] d, input logic [LW-1:0] n);
        @(posedge CLK);
        #1;
        bus.srcAdrs = s;
        bus.dstAdrs = d;
        bus.len     = n;
        bus.start   = 1'b1;
        @(posedge CLK);
        #1 bus.start = 1'b0;
    endtask

    task automatic expect_wr(input int adr, input logic [DW-1:0] dat);
        exp_wr_q.push_back({DW'(adr), dat});
    endtask

    task automatic expect_done(input logic e, input int busy_cycles, input logic [DW-1:0] sum);
        exp_err_q.push_back(e);
        exp_busy_q.push_back(8'(busy_cycles));
        exp_sum_q.push_back(sum);
    endtask

    // Returns the number of negedges waited after the start was accepted.
    task automatic wait_done(input string name, output int lat);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge CLK);
            if (bus.done) break;
        end
        lat = k;
        if (k == 300) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: no done after %0d cycles", name, k);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bus.start   = 1'b0;
        bus.srcAdrs = '0;
        bus.dstAdrs = '0;
        bus.len     = '0;

        repeat (2) @(posedge CLK);
        #1;
        check("rst_busy",    64'(bus.busy),     64'd0);
        check("rst_done",    64'(bus.done),     64'd0);
        check("rst_err",     64'(bus.err),      64'd0);
        check("rst_memWE",   64'(bus.memWE),    64'd0);
        check("rst_memAdrs", 64'(bus.memAdrs),  64'd0);
        check("rst_memWD",   64'(bus.memWD),    64'd0);
        check("rst_state",   64'(bus.dbgState), 64'd0);
`ifdef DMA_CHECKSUM_EN
        check("rst_checksum", 64'(bus.checksum), 64'd0);
`endif
        RST_N = 1'b1;
        for (int i = 0; i < DEPTH; i++) poke(i, '0);

        // 1: plain 4-word copy
        for (int i = 0; i < 4; i++) poke(i, DW'(i + 1));
        for (int i = 0; i < 4; i++) expect_wr(10 + i, DW'(i + 1));
        expect_done(1'b0, 8, 32'd10);
        req(0, 10, 4);
        wait_done("t1", lat);
        check("t1_latency", 64'(lat), 64'd8);
        for (int i = 0; i < 4; i++) check("t1_mem", 64'(mem[10 + i]), 64'(i + 1));
        check("t1_adrs_hold", 64'(bus.memAdrs), 64'd13);

        // 2: zero length
        expect_done(1'b0, 0, 32'd0);
        req(5, 6, 0);
        wait_done("t2", lat);
        check("t2_latency", 64'(lat), 64'd0);

        // 3: source range overflow (45+4 > 48)
        expect_done(1'b1, 0, 32'd0);
        req(45, 0, 4);
        wait_done("t3", lat);
        check("t3_latency", 64'(lat), 64'd0);
        repeat (2) @(negedge CLK);
        check("t3_err_sticky", 64'(bus.err), 64'd1);
        check("t3_state_idle", 64'(bus.dbgState), 64'd0);
        check("t3_mem0", 64'(mem[0]), 64'd1);
        check("t3_adrs_hold", 64'(bus.memAdrs), 64'd13);

        // 4: ignored restart, then reset during WRITE of word 2
        for (int i = 0; i < 4; i++) poke(20 + i, DW'(32'hA0 + i));
        expect_wr(30, 32'hA0);
        expect_wr(31, 32'hA1);
        req(20, 30, 4);
        @(posedge CLK);
        #1;
        bus.srcAdrs = 0;
        bus.dstAdrs = 40;
        bus.len     = 2;
        bus.start   = 1'b1;
        @(posedge CLK);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("t4_rst_memWE", 64'(bus.memWE),    64'd0);
        check("t4_rst_busy",  64'(bus.busy),     64'd0);
        check("t4_rst_state", 64'(bus.dbgState), 64'd0);
        check("t4_rst_err",   64'(bus.err),      64'd0);
        @(posedge CLK);
        #1 RST_N = 1'b1;
        check("t4_mem30", 64'(mem[30]), 64'hA0);
        check("t4_mem31", 64'(mem[31]), 64'hA1);
        check("t4_mem32", 64'(mem[32]), 64'd0);
        check("t4_mem33", 64'(mem[33]), 64'd0);
        check("t4_mem40", 64'(mem[40]), 64'd0);

        // 5: overlapping ascending copy
        poke(0, 7);
        poke(1, 8);
        poke(2, 9);
        poke(3, 0);
        for (int i = 1; i <= 3; i++) expect_wr(i, 32'd7);
        expect_done(1'b0, 6, 32'd21);
        req(0, 1, 3);
        wait_done("t5", lat);
        for (int i = 1; i <= 3; i++) check("t5_mem", 64'(mem[i]), 64'd7);

        // 6: checksum wrap, destination ending exactly at the top of memory
        poke(40, 32'hFFFF_FFFF);
        poke(41, 32'h0000_0002);
        expect_wr(46, 32'hFFFF_FFFF);
        expect_wr(47, 32'h0000_0002);
        expect_done(1'b0, 4, 32'h0000_0001);
        req(40, 46, 2);
        wait_done("t6", lat);
        check("t6_mem46", 64'(mem[46]), 64'hFFFF_FFFF);
        check("t6_mem47", 64'(mem[47]), 64'h2);

        repeat (3) @(negedge CLK);
        check("wr_q_empty",   64'(exp_wr_q.size()),  64'd0);
        check("done_q_empty", 64'(exp_err_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
